spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised SPI master for the communication-protocol subsystem. It supports configurable word width, sclk divider, all four SPI modes, MSB/LSB-first ordering and NUM_CS one-hot chip selects. Transfers use a start/busy/done handshake, so a host FSM or register bank can issue back-to-back words to several slaves on one bus.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_CS, 4, number of chip-select lines (>=1)
CLK_DIV, 4, clk cycles per sclk half-period (>=1)
CS_W, $clog2(NUM_CS) (min 1), width of cs_sel

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  request transfer (sampled when busy=0)
tx_data  in  DATA_W  word to send
cs_sel  in  CS_W  slave index
cpol  in  1  sclk idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  1: LSB shifted first
miso  in  1  serial data from slave
sclk  out  1  SPI clock
mosi  out  1  serial data to slave
cs_n  out  NUM_CS  active-low chip selects, one-hot-low when active
busy  out  1  transfer in progress
done  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  last received word

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset: sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, rx_data=0, FSM=IDLE, internal counters=0. Reset mid-transfer aborts immediately with no done pulse.
- FSM states: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE: sclk=cpol (registered), cs_n all 1. start=1 latches tx_data, cs_sel, cpol, cpha and lsb_first, then goes to SETUP. Inputs are ignored for the rest of the transfer.
- SETUP: the selected cs_n bit goes low on entry. Stay CLK_DIV cycles. If cpha=0, mosi presents the first bit on entry.
- XFER: 2*DATA_W sclk edges, one every CLK_DIV clk cycles. Odd edges are leading, even edges are trailing.
  - cpha=0: sample miso on the leading edge; drive the next bit on the trailing edge (except after the last bit).
  - cpha=1: drive a bit on the leading edge; sample on the trailing edge.
  - After the final edge sclk equals cpol. Then go to HOLD.
- HOLD: CLK_DIV cycles with cs_n still asserted, then go to DONE.
- DONE: cs_n all 1, rx_data updated with the assembled word (bit order per lsb_first), done=1 for exactly one cycle, busy=0. start is accepted in this cycle (next transfer enters SETUP; cs_n is high for >=1 cycle between words). Otherwise go to IDLE.
- busy=1 in SETUP, XFER and HOLD; 0 in IDLE and DONE. start while busy=1 is ignored.
- Latency: start sampled at edge 0 → done high in cycle (2*DATA_W+2)*CLK_DIV+1.
- cs_sel>=NUM_CS: no cs_n asserted; the transfer still runs and done still pulses.
- mosi holds its last bit after the transfer. rx_data holds its value until the next DONE.

Optional Feature:
SPI_LOOPBACK_EN: when defined, adds input port loopback (1 bit). With loopback=1, the receive path samples the internal mosi instead of miso. With loopback=0, or when the macro is undefined, miso is sampled. Without the macro the port does not exist.

Test Plan:
- DATA_W=8, CLK_DIV=2, mode 0, cs_sel=1, tx 0xA5, slave model returns 0x3C → cs_n=4'b1101 during transfer, mosi sequence 1,0,1,0,0,1,0,1, rx_data=0x3C, done in cycle 37.
- Mode 3 (cpol=1, cpha=1), tx 0x81, slave returns 0x7E → sclk idles high, 8 rising sample edges, mosi 1,0,0,0,0,0,0,1, rx_data=0x7E.
- lsb_first=1, tx 0x01, slave sends 0x80 LSB-first → mosi first bit 1 then seven 0s, rx_data=0x80.
- start pulsed mid-transfer with tx 0xFF → ignored, original word completes. start held in the DONE cycle with tx 0x55 → second transfer begins, cs_n high for exactly 1 cycle between words.
- cs_sel=5 with NUM_CS=4 → cs_n stays 4'b1111, done still pulses at cycle 37. rst asserted at bit 4 → cs_n=1111, sclk=0, busy=0 immediately, no done.
- SPI_LOOPBACK_EN defined, loopback=1, miso tied 1, tx 0x5A → rx_data=0x5A. loopback=0 → rx_data=0xFF.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master, all four modes, MSB/LSB first,
// one-hot-low chip selects. Define SPI_LOOPBACK_EN to add loopback_i.

module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_CS-1:0] cs_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                cpha_q;
    logic                lsb_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rx_data_q;

    logic                accept;
    logic                tick;
    logic                lead;
    logic                drive;
    logic                sample;
    logic                drv_bit;
    logic                first_bit;
    logic                rx_bit;
    logic [EDGE_W-1:0]   edge_d;
    logic [NUM_CS-1:0]   cs_n_d;
    logic [DATA_W-1:0]   rx_d;

    // Bit i of a word in shift order (MSB-first or LSB-first).
    function automatic logic pick(input logic [DATA_W-1:0] w,
                                  input logic [BIT_W-1:0]  i,
                                  input logic              lsb);
        logic [BIT_W-1:0] p;
        p = lsb ? i : BIT_W'(DATA_W - 1) - i;
        return w[p];
    endfunction

    // Edge bookkeeping, bit selection, chip-select decode and rx shift.
    always_comb begin
        edge_d    = edge_q + 1'b1;
        tick      = (cnt_q == CNT_MAX);
        accept    = start_i && (state_q == IDLE || state_q == DONE);
        lead      = edge_d[0];
        drive     = cpha_q ? lead : (!lead && edge_d != LAST_EDGE);
        sample    = cpha_q ? !lead : lead;
        drv_bit   = pick(tx_q, BIT_W'(edge_d >> 1), lsb_q);
        first_bit = pick(tx_data_i, '0, lsb_first_i);
`ifdef SPI_LOOPBACK_EN
        rx_bit    = loopback_i ? mosi_q : miso_i;
`else
        rx_bit    = miso_i;
`endif
        rx_d      = lsb_q ? {rx_bit, rx_q[DATA_W-1:1]}
                          : {rx_q[DATA_W-2:0], rx_bit};
        cs_n_d    = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel_i == CS_W'(i)) cs_n_d[i] = 1'b0;
        end
    end

    // Transfer FSM with registered SPI and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q <= SETUP;
                cnt_q   <= '0;
                edge_q  <= '0;
                tx_q    <= tx_data_i;
                rx_q    <= '0;
                cpha_q  <= cpha_i;
                lsb_q   <= lsb_first_i;
                sclk_q  <= cpol_i;
                cs_n_q  <= cs_n_d;
                busy_q  <= 1'b1;
                if (!cpha_i) mosi_q <= first_bit;
            end else begin
                unique case (state_q)
                    IDLE: sclk_q <= cpol_i;
                    SETUP: begin
                        if (tick) begin
                            cnt_q   <= '0;
                            state_q <= XFER;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    XFER: begin
                        if (tick) begin
                            cnt_q  <= '0;
                            sclk_q <= ~sclk_q;
                            edge_q <= edge_d;
                            if (drive)  mosi_q <= drv_bit;
                            if (sample) rx_q   <= rx_d;
                            if (edge_d == LAST_EDGE) begin
                                edge_q  <= '0;
                                state_q <= HOLD;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            cnt_q     <= '0;
                            state_q   <= DONE;
                            cs_n_q    <= '1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rx_data_q <= rx_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed bench for spi_master_param
// (DATA_W=8, NUM_CS=4, CLK_DIV=2, CS_W=3 so out-of-range selects fit).

module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [2:0] cs_sel = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsb_first = 1'b0;
    logic       miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif
    logic       sclk;
    logic       mosi;
    logic [3:0] cs_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] mo;
    logic [3:0] csv;
    int         dcyc;
    int         ne;
    int         seen;

    always #5 clk = ~clk;

    spi_master_param #(
        .DATA_W (8),
        .NUM_CS (4),
        .CLK_DIV(2),
        .CS_W   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .tx_data_i  (tx_data),
        .cs_sel_i   (cs_sel),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .lsb_first_i(lsb_first),
`ifdef SPI_LOOPBACK_EN
        .loopback_i (loopback),
`endif
        .miso_i     (miso),
        .sclk_o     (sclk),
        .mosi_o     (mosi),
        .cs_n_o     (cs_n),
        .busy_o     (busy),
        .done_o     (done),
        .rx_data_o  (rx_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one word with a slave model; pre=1 means start was already taken.
    task automatic xfer(input logic [7:0] tx, input logic [2:0] sel,
                        input logic pol, input logic pha, input logic lsb,
                        input logic [7:0] sw, input bit pre, input int glitch,
                        output logic [7:0] mo_o, output int dcyc_o,
                        output logic [3:0] csv_o, output int ne_o);
        int         c;
        logic       prev;
        logic       lead;
        logic [2:0] k3;
        tx_data   = tx;
        cs_sel    = sel;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        miso      = pha ? 1'b0 : (lsb ? sw[0] : sw[7]);
        if (!pre) begin
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        mo_o   = '0;
        dcyc_o = 0;
        csv_o  = 4'hF;
        ne_o   = 0;
        c      = 1;
        prev   = sclk;
        while (dcyc_o == 0 && c < 200) begin
            if (c == glitch) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end else if (c == glitch + 1) begin
                start = 1'b0;
            end
            if (sclk !== prev) begin
                prev = sclk;
                ne_o++;
                lead = (ne_o % 2 == 1);
                k3   = 3'(ne_o / 2);
                if (pha ? lead : (!lead && ne_o < 16))
                    miso = lsb ? sw[k3] : sw[3'd7 - k3];
                if (lead != pha)
                    mo_o = lsb ? {mosi, mo_o[7:1]} : {mo_o[6:0], mosi};
            end
            if (ne_o == 4) csv_o = cs_n;
            if (done === 1'b1) begin
                dcyc_o = c;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rx", 32'(rx_data), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // mode 0, MSB first, slave 1
        xfer(8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 0, mo, dcyc, csv, ne);
        chk("m0_mosi", 32'(mo), 32'hA5);
        chk("m0_rx", 32'(rx_data), 32'h3C);
        chk("m0_cycle", 32'(dcyc), 32'd37);
        chk("m0_cs", 32'(csv), 32'hD);
        chk("m0_edges", 32'(ne), 32'd16);
        chk("m0_sclk_end", 32'(sclk), 32'h0);
        chk("m0_busy_done", 32'(busy), 32'h0);
        chk("m0_cs_done", 32'(cs_n), 32'hF);
        @(posedge clk);
        #1;
        chk("m0_done_pulse", 32'(done), 32'h0);
        chk("m0_mosi_hold", 32'(mosi), 32'h1);
        chk("m0_rx_hold", 32'(rx_data), 32'h3C);

        // mode 3, idle high
        cpol = 1'b1;
        cpha = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("m3_idle", 32'(sclk), 32'h1);
        xfer(8'h81, 3'd0, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b0, 0, mo, dcyc, csv, ne);
        chk("m3_mosi", 32'(mo), 32'h81);
        chk("m3_rx", 32'(rx_data), 32'h7E);
        chk("m3_cs", 32'(csv), 32'hE);
        chk("m3_edges", 32'(ne), 32'd16);
        chk("m3_sclk_end", 32'(sclk), 32'h1);
        chk("m3_cycle", 32'(dcyc), 32'd37);
        @(posedge clk);
        #1;

        // LSB first, slave 2
        xfer(8'h01, 3'd2, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 0, mo, dcyc, csv, ne);
        chk("lsb_mosi", 32'(mo), 32'h01);
        chk("lsb_rx", 32'(rx_data), 32'h80);
        chk("lsb_cs", 32'(csv), 32'hB);
        @(posedge clk);
        #1;

        // start mid-transfer ignored, then back-to-back from DONE
        xfer(8'hC3, 3'd3, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 10, mo, dcyc, csv, ne);
        chk("gl_mosi", 32'(mo), 32'hC3);
        chk("gl_rx", 32'(rx_data), 32'h96);
        chk("gl_cycle", 32'(dcyc), 32'd37);
        chk("gl_cs", 32'(csv), 32'h7);
        chk("b2b_gap_cs", 32'(cs_n), 32'hF);
        start   = 1'b1;
        tx_data = 8'h55;
        cs_sel  = 3'd1;
        cpol    = 1'b0;
        cpha    = 1'b0;
        lsb_first = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_cs", 32'(cs_n), 32'hD);
        chk("b2b_busy", 32'(busy), 32'h1);
        xfer(8'h55, 3'd1, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b1, 0, mo, dcyc, csv, ne);
        chk("b2b_mosi", 32'(mo), 32'h55);
        chk("b2b_rx", 32'(rx_data), 32'h0F);
        chk("b2b_cycle", 32'(dcyc), 32'd37);
        @(posedge clk);
        #1;

        // out-of-range select
        xfer(8'h3C, 3'd5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 0, mo, dcyc, csv, ne);
        chk("oor_cs", 32'(csv), 32'hF);
        chk("oor_cycle", 32'(dcyc), 32'd37);
        chk("oor_rx", 32'(rx_data), 32'hA5);
        @(posedge clk);
        #1;

        // reset mid-transfer
        cpol    = 1'b1;
        cpha    = 1'b1;
        tx_data = 8'hFF;
        cs_sel  = 3'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        chk("ar_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("ar_cs", 32'(cs_n), 32'hF);
        chk("ar_sclk", 32'(sclk), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk("ar_no_done", 32'(seen), 32'h0);
        chk("ar_idle_busy", 32'(busy), 32'h0);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1;
        xfer(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 0, mo, dcyc, csv, ne);
        chk("lb_on_rx", 32'(rx_data), 32'h5A);
        @(posedge clk);
        #1;
        loopback = 1'b0;
        xfer(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 0, mo, dcyc, csv, ne);
        chk("lb_off_rx", 32'(rx_data), 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
